// File: rtl/seq_pkg.sv
// seq_pkg: state encodings, RV32I major opcodes and trap cause codes shared by the sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } seq_state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    function automatic logic is_legal_opcode(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: down-counter that flags the TIMEOUT_CYCLES-th counted wait cycle since the last clear.
// Only instantiated when SEQ_MEM_TIMEOUT_EN is defined. TIMEOUT_CYCLES must be at least 1.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int unsigned     CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] remain_q, remain_d;

    // Reload on clear, otherwise count down on each waiting cycle and park at zero.
    always_comb begin
        remain_d = remain_q;
        if (clear) begin
            remain_d = LOAD_VAL;
        end else if (count_en && (remain_q != '0)) begin
            remain_d = remain_q - CW'(1);
        end
    end

    // Remaining-wait register.
    always_ff @(posedge clk) begin
        if (rst) begin
            remain_q <= LOAD_VAL;
        end else begin
            remain_q <= remain_d;
        end
    end

    // Terminal count: this waiting cycle is the last one allowed.
    assign expired = count_en && (remain_q == '0);

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: steps the single-issue RV32I datapath through FETCH/DECODE/EXEC/MEM/WB,
// turns Reg_W/Mem_W levels into single-cycle strobes, raises a sticky trap, counts retirements.
// Optional feature macro: SEQ_MEM_TIMEOUT_EN (trap with cause 2 when an ack never arrives).
//
// state  | meaning
// FETCH  | imem_req held; unstalled imem_ack latches IR
// DECODE | opcode legality check
// EXEC   | route: LOAD/STORE to MEM, BRANCH retires, rest to WB
// MEM    | dmem_req held; unstalled dmem_ack completes access
// WB     | register write strobe and PC update
// TRAP   | all strobes low, trap sticky until rst
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             reg_w_in,
    input  logic             mem_r_in,
    input  logic             mem_w_in,
    input  logic             stall,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic [2:0]       state_o,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);
    seq_state_e       state_q, state_d;
    logic             trap_q, trap_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, reg_we_c;
    logic             timeout_hit;

    // Access direction comes from the opcode; Mem_R carries no extra information here.
    logic unused_inputs;
    assign unused_inputs = mem_r_in;

`ifdef SEQ_MEM_TIMEOUT_EN
    logic ack_taken, wait_count, wait_clear;
    assign ack_taken  = !stall && (((state_q == ST_FETCH) && imem_ack) ||
                                   ((state_q == ST_MEM) && dmem_ack));
    assign wait_count = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !ack_taken;
    assign wait_clear = (state_d != state_q);

    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (wait_clear),
        .count_en (wait_count),
        .expired  (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit        = 1'b0;
`endif

    // Next state, strobes and trap bookkeeping; stall freezes state and suppresses write strobes.
    always_comb begin
        state_d    = state_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        reg_we_c   = 1'b0;
        trap_d     = trap_q;
        cause_d    = cause_q;
        case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack && !stall) begin
                    ir_we_c = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!stall) begin
                    state_d = is_legal_opcode(opcode) ? ST_EXEC : ST_TRAP;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
                        state_d = ST_MEM;
                    end else if (opcode == OPC_BRANCH) begin
                        pc_we_c = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = mem_w_in;
                if (dmem_ack && !stall) begin
                    if (opcode == OPC_STORE) begin
                        pc_we_c = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                if (!stall) begin
                    reg_we_c = reg_w_in;
                    pc_we_c  = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
        if (timeout_hit) begin
            state_d = ST_TRAP;
        end
        if ((state_q != ST_TRAP) && (state_d == ST_TRAP)) begin
            trap_d  = 1'b1;
            cause_d = timeout_hit ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
        end
        retired_d = retired_q + CNT_W'(pc_we_c);
    end

    // State, trap and retirement registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    // A reset cycle abandons any access: requests and strobes drop immediately.
    assign imem_req   = imem_req_c & ~rst;
    assign dmem_req   = dmem_req_c & ~rst;
    assign dmem_we    = dmem_we_c & ~rst;
    assign ir_we      = ir_we_c & ~rst;
    assign pc_we      = pc_we_c & ~rst;
    assign reg_we     = reg_we_c & ~rst;
    assign state_o    = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: builds the expected per-cycle trace of each instruction from the
// stage rules (fetch wait, decode, exec routing, memory wait, writeback) and replays it against the DUT.
module tb_multicycle_sequencer;

    localparam int CNT_W = 4;
    localparam int TMO   = 4;
`ifdef SEQ_MEM_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
    localparam int MAXW   = TMO - 1;
`else
    localparam bit TMO_ON = 1'b0;
    localparam int MAXW   = 5;
`endif

    localparam logic [6:0] O_ADD = 7'b0110011;
    localparam logic [6:0] O_LD  = 7'b0000011;
    localparam logic [6:0] O_ST  = 7'b0100011;
    localparam logic [6:0] O_BR  = 7'b1100011;
    localparam logic [6:0] LEGAL [0:8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    typedef struct packed {
        logic [2:0] st;
        logic       ireq, dreq, dwe, irwe, pcwe, rwe, trp;
        logic [1:0] cause;
    } exp_t;
    typedef struct packed { logic stall, iack, dack; } stim_t;

    logic             clk, rst, reg_w_in, mem_r_in, mem_w_in, stall, imem_ack, dmem_ack;
    logic [6:0]       opcode;
    logic             imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, trap;
    logic [2:0]       state_o;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;

    stim_t sq[$];
    exp_t  eq[$];
    int    total = 0;
    int    bad   = 0;
    int    exp_ret = 0;

    multicycle_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .reg_w_in(reg_w_in), .mem_r_in(mem_r_in),
        .mem_w_in(mem_w_in), .stall(stall), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
        .pc_we(pc_we), .reg_we(reg_we), .state_o(state_o), .trap(trap),
        .trap_cause(trap_cause), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    function automatic bit is_legal(input logic [6:0] o);
        foreach (LEGAL[i]) if (LEGAL[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t mk(input int st, input bit ir, input bit dr, input bit dw, input bit iw,
                                input bit pw, input bit rw, input bit tp, input int cs);
        exp_t e;
        e.st = 3'(st); e.ireq = ir; e.dreq = dr; e.dwe = dw; e.irwe = iw;
        e.pcwe = pw; e.rwe = rw; e.trp = tp; e.cause = 2'(cs);
        return e;
    endfunction

    function automatic exp_t obs();
        exp_t e;
        e.st = state_o; e.ireq = imem_req; e.dreq = dmem_req; e.dwe = dmem_we & dmem_req;
        e.irwe = ir_we; e.pcwe = pc_we; e.rwe = reg_we; e.trp = trap; e.cause = trap_cause;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] want);
        total++;
        assert (act === want) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, want);
        end
    endtask

    task automatic push(input logic stl, input logic ia, input logic da, input exp_t e);
        stim_t s;
        s.stall = stl; s.iack = ia; s.dack = da;
        sq.push_back(s);
        eq.push_back(e);
    endtask

    // Cycles spent waiting for an ack (no ack, or ack masked by stall); may end in a timeout.
    task automatic plan_wait(input int st, input bit is_i, input bit dw, input int dly, input int nst,
                             output bit tmo);
        int waited = 0;
        tmo = 1'b0;
        for (int i = 0; i < dly + nst; i++) begin
            if (i < dly) push(rb(), is_i ? 1'b0 : rb(), is_i ? rb() : 1'b0, mk(st, is_i, !is_i, !is_i && dw, 0, 0, 0, 0, 0));
            else         push(1'b1, is_i ? 1'b1 : rb(), is_i ? rb() : 1'b1, mk(st, is_i, !is_i, !is_i && dw, 0, 0, 0, 0, 0));
            waited++;
            if (TMO_ON && waited == TMO) begin
                tmo = 1'b1;
                return;
            end
        end
    endtask

    task automatic plan_hold(input int st, input int n);
        repeat (n) push(1'b1, rb(), rb(), mk(st, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic plan_trap(input int cs, input int n);
        repeat (n) push(rb(), rb(), rb(), mk(5, 0, 0, 0, 0, 0, 0, 1, cs));
    endtask

    // Whole instruction trace. Negative delay means random within the wait budget.
    task automatic plan_instr(input logic [6:0] opc, input logic rw, input int idly, input int istl,
                              input int ddly, input int dstl, input bit rnd, output int outcome);
        bit tmo, ld, st, br;
        ld = (opc == O_LD); st = (opc == O_ST); br = (opc == O_BR);
        opcode = opc; reg_w_in = rw; mem_w_in = st; mem_r_in = ld;
        outcome = 0;
        if (idly < 0) begin
            idly = $urandom_range(0, MAXW);
            istl = $urandom_range(0, MAXW - idly);
        end
        plan_wait(0, 1'b1, 1'b0, idly, istl, tmo);
        if (tmo) begin plan_trap(2, 5); outcome = 1; return; end
        push(1'b0, 1'b1, rb(), mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        plan_hold(1, rnd ? $urandom_range(0, 2) : 0);
        push(1'b0, rb(), rb(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        if (!is_legal(opc)) begin plan_trap(1, 10); outcome = 1; return; end
        plan_hold(2, rnd ? $urandom_range(0, 2) : 0);
        if (br) begin
            push(1'b0, rb(), rb(), mk(2, 0, 0, 0, 0, 1, 0, 0, 0));
            return;
        end
        push(1'b0, rb(), rb(), mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
        if (ld || st) begin
            if (ddly < 0) begin
                ddly = $urandom_range(0, MAXW);
                dstl = $urandom_range(0, MAXW - ddly);
            end
            plan_wait(3, 1'b0, st, ddly, dstl, tmo);
            if (tmo) begin plan_trap(2, 5); outcome = 1; return; end
            push(1'b0, rb(), 1'b1, mk(3, 0, 1, st, 0, st, 0, 0, 0));
            if (st) return;
        end
        plan_hold(4, rnd ? $urandom_range(0, 2) : 0);
        push(1'b0, rb(), rb(), mk(4, 0, 0, 0, 0, 1, rw, 0, 0));
    endtask

    task automatic run_trace(input string tag);
        stim_t s;
        exp_t  e;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            e = eq.pop_front();
            @(negedge clk);
            rst = 1'b0; stall = s.stall; imem_ack = s.iack; dmem_ack = s.dack;
            #1;
            chk(tag, 16'(obs()), 16'(e));
        end
    endtask

    task automatic do_reset(input logic da);
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; imem_ack = 1'b0; dmem_ack = da;
        #1;
        chk("reset strobes", 16'({imem_req, dmem_req, ir_we, pc_we, reg_we}), 16'd0);
        @(posedge clk);
        #1;
        chk("reset regs", 16'({state_o, trap, trap_cause, retired}), 16'd0);
        exp_ret = 0;
    endtask

    task automatic finish_instr(input string tag, input int outcome);
        run_trace(tag);
        @(posedge clk);
        #1;
        if (outcome == 0) exp_ret = (exp_ret + 1) % (1 << CNT_W);
        chk({tag, " retired"}, 16'(retired), 16'(exp_ret));
        if (outcome != 0) do_reset(1'b0);
    endtask

    initial begin
        int         oc;
        logic [6:0] o;
        rst = 1'b1; stall = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        opcode = 7'd0; reg_w_in = 1'b0; mem_r_in = 1'b0; mem_w_in = 1'b0;

        do_reset(1'b0);

        plan_instr(O_ADD, 1'b1, 2, 0, 0, 0, 1'b0, oc);
        finish_instr("add", oc);

        plan_instr(O_LD, 1'b1, 0, 0, 3, 0, 1'b0, oc);
        finish_instr("lw", oc);

        plan_instr(O_ST, 1'b1, 1, 0, 2, 0, 1'b0, oc);
        finish_instr("sw", oc);

        plan_instr(O_BR, 1'b1, 0, 0, 0, 0, 1'b0, oc);
        finish_instr("branch", oc);

        plan_instr(O_ADD, 1'b1, 0, 3, 0, 0, 1'b0, oc);
        finish_instr("fetch stall", oc);

        plan_instr(7'b0000000, 1'b1, 0, 0, 0, 0, 1'b0, oc);
        finish_instr("illegal", oc);

        plan_instr(O_LD, 1'b1, 0, 0, 70, 0, 1'b0, oc);
        finish_instr("dmem wait", oc);

        // Reset while a load is waiting in MEM, with a stale dmem_ack arriving afterwards.
        opcode = O_LD; reg_w_in = 1'b1; mem_w_in = 1'b0; mem_r_in = 1'b1;
        push(1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        push(1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        push(1'b0, 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
        push(1'b0, 1'b0, 1'b0, mk(3, 0, 1, 0, 0, 0, 0, 0, 0));
        push(1'b0, 1'b0, 1'b0, mk(3, 0, 1, 0, 0, 0, 0, 0, 0));
        run_trace("mid access");
        do_reset(1'b1);
        push(1'b0, 1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        plan_instr(O_ADD, 1'b1, 0, 0, 0, 0, 1'b0, oc);
        finish_instr("late ack", oc);

        do_reset(1'b0);
        for (int i = 0; i < 17; i++) begin
            plan_instr(O_ADD, 1'b0, 0, 0, 0, 0, 1'b0, oc);
            finish_instr("wrap", oc);
        end

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                do o = 7'($urandom_range(0, 127)); while (is_legal(o));
            end else begin
                o = LEGAL[$urandom_range(0, 8)];
            end
            plan_instr(o, rb(), -1, 0, -1, 0, 1'b1, oc);
            finish_instr("random", oc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
